// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters (core C, DMA D), the arbiter and the memory.
// slave = arbiter side, master = requester/memory side.
interface dmem_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_wr;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [2:0]    c_func3;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [2:0]    d_func3;
  logic          d_lock;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_func3;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  c_req, c_wr, c_addr, c_wdata, c_func3,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_wr, d_addr, d_wdata, d_func3, d_lock,
    output d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_wr, mem_wdata, mem_func3,
    input  mem_rdata
  );

  modport master (
    output c_req, c_wr, c_addr, c_wdata, c_func3,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_wr, d_addr, d_wdata, d_func3, d_lock,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_wr, mem_wdata, mem_func3,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core port C has fixed priority, DMA port D is protected
// by a starvation counter and may hold the memory across cycles with d_lock.
module dmem_arbiter #(
  parameter int AW           = 11,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  dmem_arbiter_if.slave bus,
  output logic [7:0] o_starve_cnt,
  output logic       o_lock_q
);
  // Handshake: a requester raises req with wr/addr/wdata/func3 and holds them unchanged until
  // its combinational gnt; the gnt cycle is the access. Writes complete on gnt, reads return
  // rdata with a one-cycle rvalid pulse in the cycle after gnt.
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]    r_starve_cnt;
  logic          r_lock_q;
  logic          r_c_rvalid;
  logic          r_d_rvalid;
  logic [DW-1:0] r_c_rdata;
  logic [DW-1:0] r_d_rdata;

  logic          w_d_prio;
  logic          w_d_gnt;
  logic          w_c_gnt;
  logic [AW-1:0] w_addr;
  logic          w_wr;
  logic [DW-1:0] w_wdata;
  logic [2:0]    w_func3;

  assign w_d_prio = r_lock_q | (r_starve_cnt == LIMIT);
  assign w_d_gnt  = bus.d_req & (w_d_prio | ~bus.c_req);
  assign w_c_gnt  = bus.c_req & ~w_d_gnt;

  // Idle bus is driven to all zeros so mem_wr can never fire without a grant.
  always_comb begin
    w_addr  = '0;
    w_wr    = 1'b0;
    w_wdata = '0;
    w_func3 = 3'b000;
    if (w_d_gnt) begin
      w_addr  = bus.d_addr;
      w_wr    = bus.d_wr;
      w_wdata = bus.d_wdata;
      w_func3 = bus.d_func3;
    end else if (w_c_gnt) begin
      w_addr  = bus.c_addr;
      w_wr    = bus.c_wr;
      w_wdata = bus.c_wdata;
      w_func3 = bus.c_func3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c_rvalid   <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_c_rdata    <= '0;
      r_d_rdata    <= '0;
      r_starve_cnt <= 8'd0;
      r_lock_q     <= 1'b0;
    end else begin
      r_c_rvalid <= w_c_gnt & ~bus.c_wr;
      r_d_rvalid <= w_d_gnt & ~bus.d_wr;
      if (w_c_gnt & ~bus.c_wr) r_c_rdata <= bus.mem_rdata;
      if (w_d_gnt & ~bus.d_wr) r_d_rdata <= bus.mem_rdata;
      if (bus.d_req & ~w_d_gnt) begin
        if (r_starve_cnt != LIMIT) r_starve_cnt <= r_starve_cnt + 8'd1;
      end else begin
        r_starve_cnt <= 8'd0;
      end
      r_lock_q <= w_d_gnt & bus.d_lock & bus.d_req;
    end
  end

  assign bus.mem_addr  = w_addr;
  assign bus.mem_wr    = w_wr;
  assign bus.mem_wdata = w_wdata;
  assign bus.mem_func3 = w_func3;
  assign bus.c_gnt     = w_c_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.c_rvalid  = r_c_rvalid;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.c_rdata   = r_c_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign o_starve_cnt  = r_starve_cnt;
  assign o_lock_q      = r_lock_q;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path (port C, MEM stage) and a loader/debug DMA path (port D).
- Selects one requester per cycle and drives the memory's address, write-enable, write-data and func3 from the winner.
- Captures read data into a register and returns it with a one-cycle valid pulse.
- Port C has fixed priority. Port D is protected by a starvation counter and can hold the memory for bursts with a lock signal.

Parameters:
- AW, 11, word-address width; matches the data memory.
- DW, 32, data width.
- STARVE_LIMIT, 4, number of consecutive denied cycles after which port D is forced to win; legal range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- c_req  in  1  core request, held until c_gnt
- c_wr  in  1  core write (1) / read (0)
- c_addr  in  AW  core word address
- c_wdata  in  DW  core write data
- c_func3  in  3  core access size/sign (SB/SH/SW, LB/LH/LW/LBU/LHU encodings)
- c_gnt  out  1  core granted this cycle (combinational)
- c_rvalid  out  1  core read data valid (registered)
- c_rdata  out  DW  core read data (registered)
- d_req, d_wr, d_addr, d_wdata, d_func3  in  1/1/AW/DW/3  DMA request fields; same rules as port C
- d_lock  in  1  DMA requests that its grant be held for the next cycle
- d_gnt  out  1  DMA granted this cycle (combinational)
- d_rvalid  out  1  DMA read data valid (registered)
- d_rdata  out  DW  DMA read data (registered)
- mem_addr  out  AW  to data memory
- mem_wr  out  1  to data memory
- mem_wdata  out  DW  to data memory
- mem_func3  out  3  to data memory
- mem_rdata  in  DW  from data memory; combinational read of mem_addr

Behaviour:
- Reset (asynchronous, immediate):
  - c_rvalid = d_rvalid = 0; c_rdata = d_rdata = 0.
  - starve_cnt = 0; lock_q = 0.
  - Any read in flight is discarded and no rvalid is produced for it.
- Arbitration (combinational, evaluated every cycle):
  - d_prio = lock_q OR (starve_cnt == STARVE_LIMIT).
  - If d_req AND (d_prio OR NOT c_req): d_gnt = 1, c_gnt = 0.
  - Else if c_req: c_gnt = 1.
  - At most one grant is asserted per cycle. With no request, both grants are 0.
- Memory drive:
  - While granted, mem_* come from the winning port's fields.
  - With no grant: mem_wr = 0, mem_addr / mem_wdata / mem_func3 = 0.
  - mem_wr is never asserted without a grant.
- Write timing: a write commits at the posedge ending the grant cycle; no response is returned. The requester treats gnt as completion.
- Read timing:
  - On the posedge ending a read-grant cycle, mem_rdata is registered into that port's rdata.
  - That port's rvalid is 1 for exactly the next cycle, so read latency is 1 cycle after gnt.
  - rdata holds its value until the next granted read on the same port.
  - Back-to-back granted reads give consecutive rvalid pulses.
- Starvation counter (8-bit, saturates at STARVE_LIMIT):
  - d_req AND NOT d_gnt: increment.
  - d_gnt OR NOT d_req: clear to 0.
- Lock:
  - lock_q <= d_gnt AND d_lock AND d_req.
  - While lock_q = 1, port D wins over port C every cycle.
  - Lock ends on the first grant cycle with d_lock = 0, or when d_req drops (lock_q clears and C wins the next cycle).
  - d_lock with no grant has no effect.
- Simultaneous events:
  - Starvation threshold and a C request in the same cycle: D wins and the counter clears.
  - Reset asserted in a grant cycle: no memory commit is guaranteed (memory has no reset), and all outputs are forced to reset values.
- Requesters must hold all request fields stable until granted. Changing them while waiting is illegal and is flagged by a bench assertion.

Test Plan:
- Single C read: mem[5] preloaded 0x1234_5678; c_req=1, c_wr=0, c_addr=5, c_func3=010 -> c_gnt=1 in the same cycle; c_rvalid=1 with c_rdata=0x12345678 next cycle, for one cycle only.
- Contention: c_req and d_req both held high with STARVE_LIMIT=4 -> c_gnt on cycles 0-3, d_gnt on cycle 4, c_gnt on cycle 5; starve_cnt reads 0 after cycle 4.
- Lock burst: d_req=1 with d_lock=1 for 3 grants then d_lock=0, c_req=1 throughout -> d_gnt for 4 consecutive cycles, then c_gnt.
- DMA write then core read: D writes 0xDEADBEEF to addr 7 with SW; next cycle C reads addr 7 with LW -> c_rdata=0xDEADBEEF. With LB instead -> c_rdata=0xFFFFFFEF.
- Reset mid-read: C read granted, reset asserted before the next posedge -> c_rvalid stays 0, c_rdata=0, starve_cnt=0, lock_q=0.
- Idle: no requests for 10 cycles -> mem_wr=0 throughout, both grants 0, both rvalid 0.
